axi_lite_req_arbiter: RTL and testbench
=======================================

// Module: axi_lite_req_arbiter
// PURPOSE
//  Shares one AXI4-Lite subordinate (axi_sub register block) between NUM_REQ local requesters.
//  Each requester issues simple single-word read/write commands; block arbitrates round-robin,
//  sequences one AXI4-Lite transaction at a time and returns data/response to the winner.
//  Sits between software/engine command ports and the axi_sub s_axi_* interface.
// PARAMETERS
//  NUM_REQ  2   number of requesters (>=2)
//  ADDR_W   32  address width, req and AXI
//  DATA_W   32  data width, req and AXI
// PORTS
//  clk            in   1               single clock, all logic rising-edge
//  resetn         in   1               asynchronous, active-low reset
//  req_valid      in   NUM_REQ         per-requester command valid
//  req_write      in   NUM_REQ         1=write, 0=read
//  req_addr       in   NUM_REQ*ADDR_W  packed, slice i = requester i
//  req_wdata      in   NUM_REQ*DATA_W  packed write data
//  req_ready      out  NUM_REQ         one-hot command accept
//  rsp_valid      out  NUM_REQ         one-hot 1-cycle completion pulse
//  rsp_rdata      out  DATA_W          read data (shared, valid with rsp_valid)
//  rsp_resp       out  2               AXI resp (shared, valid with rsp_valid)
//  m_axi_awaddr/awvalid/awready, wdata/wvalid/wready, bresp/bvalid/bready     AXI4-Lite write ch.
//  m_axi_araddr/arvalid/arready, rdata/rresp/rvalid/rready                     AXI4-Lite read ch.
// BEHAVIOUR
//  Reset: state IDLE, RR pointer=0, all valid/ready outputs 0, rsp_rdata=0, rsp_resp=0, m_axi_* addr/data 0.
//  FSM: IDLE -> WR_ADDR | RD_ADDR -> WR_RESP | RD_DATA -> RSP -> IDLE. One transaction outstanding.
//  IDLE: grant = first req_valid at/after pointer (round-robin); req_ready[grant]=1 combinationally,
//   only in IDLE. Accept on req_valid&req_ready: register addr/wdata/write/grant; pointer=grant+1 mod NUM_REQ.
//  WR_ADDR: awvalid=1 and wvalid=1 registered from next cycle; each drops independently after its own
//   handshake; both done -> WR_RESP. bready=1 only in WR_RESP; on bvalid capture bresp -> RSP.
//  RD_ADDR: arvalid=1 until arready -> RD_DATA. rready=1 only in RD_DATA; on rvalid capture rdata/rresp -> RSP.
//  RSP: rsp_valid[grant]=1 one cycle; rsp_rdata (0 for writes), rsp_resp held until next RSP.
//  Latency: accept T, valids T+1; zero-wait subordinate -> RESP T+2, rsp_valid T+3 (write: wait on both).
//  valid signals never drop before handshake; addr/data stable while valid (AXI rule).
//  Requester must hold req_* stable until req_ready; req_valid deassertion before accept = withdrawn.
//  Simultaneous requests: lowest index at/after pointer wins; losers wait, no starvation (bound NUM_REQ-1 txns).
//  Requester re-asserting in same cycle as its rsp_valid is accepted earliest in following IDLE cycle.
//  Non-OKAY resp passed through unchanged; no retry. No timeout: hung subordinate stalls block.
//  resetn low mid-transaction: immediate return to reset values; transaction dropped, no rsp_valid.
// STRUCTURE
//  axi_lite_arb_pkg: state_t enum {IDLE,WR_ADDR,WR_RESP,RD_ADDR,RD_DATA,RSP}; RESP_OKAY=2'b00,
//   RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
//  Sub-module rr_arbiter #(N): req vector + pointer in, one-hot grant + any_grant out, purely combinational.
//  Top: FSM, capture regs, AXI channel drivers.
// TESTING (bench: axi_lite_req_arbiter + axi_sub, clk 100 MHz)
//  1 req0 read 0x0 after reset -> one AR at 0x0, rsp_valid[0] pulse, rsp_rdata=0x00000000, rsp_resp=OKAY.
//  2 req0 write 0x0=0xDEADBEEF, then req1 read 0x0 -> AW+W, bresp OKAY, rsp_rdata=0xDEADBEEF to req1.
//  3 req0 and req1 assert same cycle, pointer=0 (write 0x20=0xADADABAB / read 0x20) -> req0 served first,
//   req1 then reads 0xADADABAB; pointer ends at 0.
//  4 both requesters hold req_valid for 8 commands -> grants alternate 0,1,0,1...; each rsp_valid once per accept.
//  5 subordinate stub: awready 3 cycles before wready, rvalid delayed 5 cycles -> valids held stable,
//   no duplicate handshakes, rsp_valid exactly once.
//  6 resetn low during WR_RESP -> all outputs reset values next edge-independent (async); no rsp_valid; clean read after.

Source files
------------

// File: rtl/axi_lite_arb_pkg.sv
// Shared types and constants for the AXI4-Lite requester arbiter.
// FSM encodings are plain localparams so legacy tools see fixed codes.
`timescale 1ns/1ps
package axi_lite_arb_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StWrAddr = 3'd1;
  localparam state_t StWrResp = 3'd2;
  localparam state_t StRdAddr = 3'd3;
  localparam state_t StRdData = 3'd4;
  localparam state_t StRsp    = 3'd5;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespExokay = 2'b01;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr wins.
// Produces a one-hot grant plus an any_grant flag.
`timescale 1ns/1ps
module rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [PtrW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic            any_grant
);

  always_comb begin
    int unsigned idx;
    grant     = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < N; i++) begin
      // Walk the ring starting at ptr, wrapping past N-1.
      idx = 32'(ptr) + i;
      if (idx >= N) begin
        idx = idx - N;
      end
      for (int unsigned j = 0; j < N; j++) begin
        if (j == idx && req[j] && !any_grant) begin
          grant[j]  = 1'b1;
          any_grant = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/axi_lite_req_arbiter.sv
// Shares one AXI4-Lite subordinate between NUM_REQ single-word requesters.
// Round-robin grant, one transaction outstanding, one-cycle response pulse.
`timescale 1ns/1ps
module axi_lite_req_arbiter
  import axi_lite_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      resetn,

  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [1:0]                rsp_resp,

  output logic [ADDR_W-1:0]         m_axi_awaddr,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [DATA_W-1:0]         m_axi_wdata,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,

  output logic [ADDR_W-1:0]         m_axi_araddr,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [DATA_W-1:0]         m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);

  state_t              state_q, state_d;
  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic [PtrW-1:0]     win_idx;
  logic [NUM_REQ-1:0]  grant_q, grant;
  logic                any_grant;
  logic                accept;

  logic                sel_write;
  logic [ADDR_W-1:0]   sel_addr, addr_q;
  logic [DATA_W-1:0]   sel_wdata, wdata_q;

  logic                awvalid_q, wvalid_q, arvalid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [1:0]          resp_q;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .any_grant (any_grant)
  );

  // Grant only matters in idle; elsewhere requesters simply wait.
  assign accept    = (state_q == StIdle) && any_grant;
  assign req_ready = accept ? grant : '0;

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    win_idx   = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (grant[j]) begin
        sel_write = req_write[j];
        sel_addr  = req_addr[j*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[j*DATA_W +: DATA_W];
        win_idx   = PtrW'(j);
      end
    end
    ptr_d = (win_idx == PtrW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (any_grant) begin
          state_d = sel_write ? StWrAddr : StRdAddr;
        end
      end
      StWrAddr: begin
        // AW and W complete independently; move on once neither is pending.
        if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
          state_d = StWrResp;
        end
      end
      StWrResp: begin
        if (m_axi_bvalid) begin
          state_d = StRsp;
        end
      end
      StRdAddr: begin
        if (m_axi_arready) begin
          state_d = StRdData;
        end
      end
      StRdData: begin
        if (m_axi_rvalid) begin
          state_d = StRsp;
        end
      end
      StRsp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      grant_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ptr_q     <= ptr_d;
        grant_q   <= grant;
        addr_q    <= sel_addr;
        wdata_q   <= sel_wdata;
        awvalid_q <= sel_write;
        wvalid_q  <= sel_write;
        arvalid_q <= !sel_write;
      end
      if (awvalid_q && m_axi_awready) begin
        awvalid_q <= 1'b0;
      end
      if (wvalid_q && m_axi_wready) begin
        wvalid_q <= 1'b0;
      end
      if (arvalid_q && m_axi_arready) begin
        arvalid_q <= 1'b0;
      end
      if (state_q == StWrResp && m_axi_bvalid) begin
        rdata_q <= '0;
        resp_q  <= m_axi_bresp;
      end
      if (state_q == StRdData && m_axi_rvalid) begin
        rdata_q <= m_axi_rdata;
        resp_q  <= m_axi_rresp;
      end
    end
  end

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = (state_q == StWrResp);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = (state_q == StRdData);

  assign rsp_valid = (state_q == StRsp) ? grant_q : '0;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;

endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
// Bench for axi_lite_req_arbiter with a behavioural AXI4-Lite register stub.
// Expected responses come from a reference memory and are queued at accept time.
`timescale 1ns/1ps
module tb_axi_lite_req_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam logic [31:0] ErrData = 32'hBAD0_BAD0;

  logic              clk = 1'b0;
  logic              resetn;
  logic [N-1:0]      req_valid, req_write, req_ready, rsp_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [DW-1:0]     rsp_rdata;
  logic [1:0]        rsp_resp;
  logic [AW-1:0]     m_axi_awaddr, m_axi_araddr;
  logic [DW-1:0]     m_axi_wdata, m_axi_rdata;
  logic              m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic              m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic              m_axi_rvalid, m_axi_rready;
  logic [1:0]        m_axi_bresp, m_axi_rresp;

  always #5 clk = ~clk;

  axi_lite_req_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .req_valid     (req_valid),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_resp      (rsp_resp),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- subordinate stub ----------------
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  int aw_hs = 0, w_hs = 0, ar_hs = 0, viol = 0;
  logic aw_got, w_got, ar_got;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [31:0] smem [64];
  logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
  logic [31:0] p_awaddr, p_wdata, p_araddr;

  assign m_axi_awready = m_axi_awvalid && !aw_got && (aw_cnt >= aw_dly);
  assign m_axi_wready  = m_axi_wvalid && !w_got && (w_cnt >= w_dly);
  assign m_axi_bvalid  = aw_got && w_got && (b_cnt >= b_dly);
  assign m_axi_bresp   = (s_awaddr >= 32'h100) ? 2'b10 : 2'b00;
  assign m_axi_arready = m_axi_arvalid && !ar_got && (ar_cnt >= ar_dly);
  assign m_axi_rvalid  = ar_got && (r_cnt >= r_dly);
  assign m_axi_rresp   = (s_araddr >= 32'h100) ? 2'b10 : 2'b00;
  assign m_axi_rdata   = (s_araddr >= 32'h100) ? ErrData : smem[s_araddr[7:2]];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      s_awaddr <= '0; s_wdata <= '0; s_araddr <= '0;
      p_awv <= 1'b0; p_awr <= 1'b0; p_wv <= 1'b0; p_wr <= 1'b0; p_arv <= 1'b0; p_arr <= 1'b0;
      p_awaddr <= '0; p_wdata <= '0; p_araddr <= '0;
      for (int i = 0; i < 64; i++) smem[i] <= '0;
    end else begin
      p_awv <= m_axi_awvalid; p_awr <= m_axi_awready; p_awaddr <= m_axi_awaddr;
      p_wv  <= m_axi_wvalid;  p_wr  <= m_axi_wready;  p_wdata  <= m_axi_wdata;
      p_arv <= m_axi_arvalid; p_arr <= m_axi_arready; p_araddr <= m_axi_araddr;
      // Valid dropped or payload changed before handshake, or valid re-raised after it.
      if ((p_awv && !p_awr && (!m_axi_awvalid || m_axi_awaddr != p_awaddr)) ||
          (p_wv && !p_wr && (!m_axi_wvalid || m_axi_wdata != p_wdata)) ||
          (p_arv && !p_arr && (!m_axi_arvalid || m_axi_araddr != p_araddr)) ||
          (m_axi_awvalid && aw_got) || (m_axi_wvalid && w_got) || (m_axi_arvalid && ar_got))
        viol <= viol + 1;
      if (m_axi_awvalid && !aw_got) begin
        if (m_axi_awready) begin
          aw_got <= 1'b1; s_awaddr <= m_axi_awaddr; aw_cnt <= 0; aw_hs <= aw_hs + 1;
        end else aw_cnt <= aw_cnt + 1;
      end
      if (m_axi_wvalid && !w_got) begin
        if (m_axi_wready) begin
          w_got <= 1'b1; s_wdata <= m_axi_wdata; w_cnt <= 0; w_hs <= w_hs + 1;
        end else w_cnt <= w_cnt + 1;
      end
      if (m_axi_bvalid && m_axi_bready) begin
        if (s_awaddr < 32'h100) smem[s_awaddr[7:2]] <= s_wdata;
        aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
      end else if (aw_got && w_got) b_cnt <= b_cnt + 1;
      if (m_axi_arvalid && !ar_got) begin
        if (m_axi_arready) begin
          ar_got <= 1'b1; s_araddr <= m_axi_araddr; ar_cnt <= 0; ar_hs <= ar_hs + 1;
        end else ar_cnt <= ar_cnt + 1;
      end
      if (m_axi_rvalid && m_axi_rready) begin
        ar_got <= 1'b0; r_cnt <= 0;
      end else if (ar_got) r_cnt <= r_cnt + 1;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct { logic write; logic [31:0] addr; logic [31:0] wdata; } cmd_t;
  typedef struct { int idx; logic [31:0] rdata; logic [1:0] resp; int cyc; bit lat; } exp_t;

  cmd_t        cq0[$], cq1[$];
  exp_t        sb[$];
  int          acc_log[$];
  logic [31:0] mdl [64];
  bit          zero_wait;
  int          rsp_cnt = 0;
  int          total = 0, passed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic cmd_t mk(input logic w, input logic [31:0] a, input logic [31:0] d);
    cmd_t c;
    c.write = w; c.addr = a; c.wdata = d;
    return c;
  endfunction

  function automatic logic [63:0] order_code();
    logic [31:0] bits = '0;
    foreach (acc_log[k]) if (acc_log[k] != 0) bits[k] = 1'b1;
    return {32'(acc_log.size()), bits};
  endfunction

  task automatic drive();
    req_valid[0] = cq0.size() > 0;
    if (cq0.size() > 0) begin
      req_write[0] = cq0[0].write; req_addr[31:0] = cq0[0].addr; req_wdata[31:0] = cq0[0].wdata;
    end
    req_valid[1] = cq1.size() > 0;
    if (cq1.size() > 0) begin
      req_write[1] = cq1[0].write; req_addr[63:32] = cq1[0].addr; req_wdata[63:32] = cq1[0].wdata;
    end
  endtask

  task automatic accept(input int i, input cmd_t c);
    exp_t e;
    logic [5:0] w = c.addr[7:2];
    e.idx = i; e.cyc = cyc; e.lat = zero_wait;
    if (c.addr >= 32'h100) begin
      e.resp = 2'b10; e.rdata = c.write ? 32'h0 : ErrData;
    end else begin
      e.resp = 2'b00;
      if (c.write) begin
        e.rdata = 32'h0; mdl[w] = c.wdata;
      end else e.rdata = mdl[w];
    end
    sb.push_back(e);
    acc_log.push_back(i);
  endtask

  task automatic check_rsp();
    exp_t e;
    if (rsp_valid !== '0) begin
      rsp_cnt++;
      if (sb.size() == 0) check("rsp_unexpected", 64'(rsp_valid), 64'(0));
      else begin
        e = sb.pop_front();
        check("rsp_onehot", 64'(rsp_valid), 64'(1) << e.idx);
        check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        check("rsp_resp", 64'(rsp_resp), 64'(e.resp));
        if (e.lat) check("rsp_latency", 64'(cyc - e.cyc), 64'(3));
      end
    end
  endtask

  task automatic run(input int budget);
    int n = 0;
    logic [N-1:0] acc;
    drive();
    while ((cq0.size() + cq1.size() + sb.size()) != 0 && n < budget) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      if (acc[0]) accept(0, cq0[0]);
      if (acc[1]) accept(1, cq1[0]);
      check_rsp();
      @(posedge clk); #1;
      if (acc[0]) cq0.delete(0);
      if (acc[1]) cq1.delete(0);
      drive();
      n++;
    end
    check("run_drained", 64'(cq0.size() + cq1.size() + sb.size()), 64'(0));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ctl"}, 64'({m_axi_araddr, req_ready, rsp_valid, m_axi_awvalid, m_axi_wvalid,
                              m_axi_bready, m_axi_arvalid, m_axi_rready}), 64'(0));
    check({tag, "_rsp"}, 64'({rsp_resp, rsp_rdata}), 64'(0));
    check({tag, "_axi"}, {m_axi_awaddr, m_axi_wdata}, 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, b_aw, b_w, b_ar, b_rsp;
    resetn = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    zero_wait = 1'b1;
    for (int i = 0; i < 64; i++) mdl[i] = '0;
    #1 check_reset_vals("rst_async");
    repeat (3) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("rst_idle");

    // 1: single read after reset
    b_ar = ar_hs; b_rsp = rsp_cnt;
    cq0.push_back(mk(1'b0, 32'h0, 32'h0));
    run(50);
    check("t1_ar_count", 64'(ar_hs - b_ar), 64'(1));
    check("t1_rsp_count", 64'(rsp_cnt - b_rsp), 64'(1));

    // 2: write by req0, read back by req1
    b_aw = aw_hs; b_w = w_hs;
    cq0.push_back(mk(1'b1, 32'h0, 32'hDEADBEEF));
    run(50);
    cq1.push_back(mk(1'b0, 32'h0, 32'h0));
    run(50);
    check("t2_aw_w_count", {32'(aw_hs - b_aw), 32'(w_hs - b_w)}, {32'd1, 32'd1});

    // 3: simultaneous requests with pointer at 0
    acc_log.delete();
    cq0.push_back(mk(1'b1, 32'h20, 32'hADADABAB));
    cq1.push_back(mk(1'b0, 32'h20, 32'h0));
    run(50);
    check("t3_order", order_code(), {32'd2, 32'h2});

    // 4: both held for 8 commands -> strict alternation
    acc_log.delete(); b_rsp = rsp_cnt;
    cq0.push_back(mk(1'b1, 32'h4, 32'h11111111));
    cq0.push_back(mk(1'b0, 32'h4, 32'h0));
    cq0.push_back(mk(1'b1, 32'h8, 32'h22222222));
    cq0.push_back(mk(1'b0, 32'hC, 32'h0));
    cq1.push_back(mk(1'b1, 32'h10, 32'h33333333));
    cq1.push_back(mk(1'b0, 32'h8, 32'h0));
    cq1.push_back(mk(1'b0, 32'h4, 32'h0));
    cq1.push_back(mk(1'b0, 32'h10, 32'h0));
    run(200);
    check("t4_order", order_code(), {32'd8, 32'hAA});
    check("t4_rsp_count", 64'(rsp_cnt - b_rsp), 64'(8));

    // 5: slow subordinate, including error responses
    aw_dly = 0; w_dly = 3; b_dly = 1; ar_dly = 2; r_dly = 5; zero_wait = 1'b0;
    b_aw = aw_hs; b_w = w_hs; b_ar = ar_hs; b_rsp = rsp_cnt;
    cq0.push_back(mk(1'b1, 32'h40, 32'h12345678));
    cq0.push_back(mk(1'b0, 32'h40, 32'h0));
    cq1.push_back(mk(1'b1, 32'h104, 32'hCAFEF00D));
    cq1.push_back(mk(1'b0, 32'h104, 32'h0));
    run(300);
    check("t5_protocol", 64'(viol), 64'(0));
    check("t5_hs_count", 64'({8'(aw_hs - b_aw), 8'(w_hs - b_w), 8'(ar_hs - b_ar)}), 64'(24'h020202));
    check("t5_rsp_count", 64'(rsp_cnt - b_rsp), 64'(4));

    // 6: reset asserted while waiting for B
    aw_dly = 0; w_dly = 0; b_dly = 20; ar_dly = 0; r_dly = 0;
    req_valid[0] = 1'b1; req_write[0] = 1'b1;
    req_addr[31:0] = 32'h8; req_wdata[31:0] = 32'h55AA55AA;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[0] && n < 10);
    check("t6_accept", 64'(req_ready[0]), 64'(1));
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!m_axi_bready && n < 10);
    check("t6_in_wr_resp", 64'(m_axi_bready), 64'(1));
    #2 resetn = 1'b0;
    #1 check_reset_vals("t6_async");
    repeat (3) @(negedge clk);
    check("t6_rsp_in_reset", 64'(rsp_valid), 64'(0));
    resetn = 1'b1;
    b_dly = 0; zero_wait = 1'b1;
    for (int i = 0; i < 64; i++) mdl[i] = '0;
    @(posedge clk); #1;
    b_rsp = rsp_cnt;
    cq1.push_back(mk(1'b0, 32'h8, 32'h0));
    run(50);
    acc_log.delete();
    cq0.push_back(mk(1'b1, 32'h8, 32'h0F0F0F0F));
    cq1.push_back(mk(1'b0, 32'h8, 32'h0));
    run(50);
    check("t6_order", order_code(), {32'd2, 32'h2});
    check("t6_rsp_count", 64'(rsp_cnt - b_rsp), 64'(3));
    check("t6_protocol", 64'(viol), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
